spi_rx_ctrl: RTL and testbench

SPI read-path controller for the ILI9341 display interface, the receive counterpart of the SPI transmit controller. After the command byte has gone out, the top level hands SCLK to this block. It clocks 1 to MAX_BYTES bytes in from the panel's SDO (MISO) line, with an optional leading dummy clock as required by RDDID and similar read commands. It presents each byte with a one-cycle valid strobe and the assembled word at completion.

---
 rtl/spi_rx_ctrl.sv | 127 ++++++++++++
 tb/tb_spi_rx_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_ctrl.sv
// rtl/spi_rx_ctrl.sv - SPI mode-0 read-path controller (dummy clock + 1..MAX_BYTES bytes in)
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         read request, honoured only in IDLE
//   rx_len        byte count (0 -> 1, saturates at MAX_BYTES), latched at start
//   dummy_en      one non-sampled SCLK period before data, latched at start
//   miso          serial data in, MSB first
//   sclk          registered SPI clock, idle low
//   busy          high in DUMMY/SHIFT
//   rx_byte       last completed byte, held until the next one
//   rx_valid      one-cycle strobe marking a new rx_byte
//   rx_word       completed bytes shifted in from the right, cleared at start
//   done          one-cycle end-of-read pulse
module spi_rx_ctrl #(
    parameter int HALF_PERIOD = 1,
    parameter int MAX_BYTES   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             rx_len,
    input  logic                   dummy_en,
    input  logic                   miso,
    output logic                   sclk,
    output logic                   busy,
    output logic [7:0]             rx_byte,
    output logic                   rx_valid,
    output logic [8*MAX_BYTES-1:0] rx_word,
    output logic                   done
);

    localparam int WORD_W = 8 * MAX_BYTES;
    localparam int PW     = $clog2(2 * HALF_PERIOD);
    localparam logic [PW-1:0] HP_C  = PW'(HALF_PERIOD);
    localparam logic [PW-1:0] P_M1  = PW'(2 * HALF_PERIOD - 1);
    // rx_len is only 3 bits wide, so the saturation limit never exceeds 7
    localparam logic [2:0]    MAX_B = (MAX_BYTES > 7) ? 3'd7 : 3'(MAX_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_DUMMY, S_SHIFT, S_DONE} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] ph, ph_nx;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_cnt;
    logic [2:0]    len_q;
    logic [2:0]    len_eff;
    logic [7:0]    shreg, shreg_nx;
    logic          active, active_nx;
    logic          period_end, capture, byte_end, last_byte;

    assign active     = (state == S_DUMMY) || (state == S_SHIFT);
    assign active_nx  = (state_nx == S_DUMMY) || (state_nx == S_SHIFT);
    assign period_end = active && (ph == P_M1);
    assign capture    = (state == S_SHIFT) && (ph == HP_C);
    assign byte_end   = (state == S_SHIFT) && period_end && (bit_cnt == 3'd0);
    assign last_byte  = (byte_cnt == len_q - 3'd1);
    assign len_eff    = (rx_len == 3'd0) ? 3'd1 : ((rx_len > MAX_B) ? MAX_B : rx_len);

    assign busy = active;
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = dummy_en ? S_DUMMY : S_SHIFT;
            S_DUMMY: if (period_end) state_nx = S_SHIFT;
            S_SHIFT: if (byte_end && last_byte) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Phase runs continuously across DUMMY->SHIFT and byte boundaries so the
    // SCLK train has no gaps; it only restarts from 0 when leaving IDLE.
    always_comb begin
        ph_nx = '0;
        if (active && active_nx && !period_end) ph_nx = ph + 1'b1;
    end

    // When HALF_PERIOD==1 the capture and the end of bit 0 land on the same
    // edge, so the completed byte must be taken from the post-capture value.
    assign shreg_nx = capture ? {shreg[6:0], miso} : shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ph       <= '0;
            sclk     <= 1'b0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
            len_q    <= 3'd0;
            shreg    <= 8'd0;
            rx_byte  <= 8'd0;
            rx_valid <= 1'b0;
            rx_word  <= '0;
        end else begin
            ph       <= ph_nx;
            sclk     <= active_nx && (ph_nx >= HP_C);
            rx_valid <= 1'b0;
            shreg    <= shreg_nx;
            if ((state == S_IDLE) && start) begin
                len_q    <= len_eff;
                bit_cnt  <= 3'd7;
                byte_cnt <= 3'd0;
                shreg    <= 8'd0;
                rx_word  <= '0;
            end
            if ((state == S_SHIFT) && period_end) begin
                if (bit_cnt == 3'd0) begin
                    bit_cnt  <= 3'd7;
                    byte_cnt <= byte_cnt + 3'd1;
                    rx_valid <= 1'b1;
                    rx_byte  <= shreg_nx;
                    rx_word  <= (rx_word << 8) | WORD_W'(shreg_nx);
                end else begin
                    bit_cnt <= bit_cnt - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_ctrl.sv
// tb/tb_spi_rx_ctrl.sv - scoreboard bench for spi_rx_ctrl (HALF_PERIOD 1 and 2 instances)
module tb_spi_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  rx_len = 3'd0;
    logic        dummy_en = 1'b0;
    logic        miso;
    logic        sel = 1'b0;
    logic        both = 1'b0;

    logic        sclk_a, busy_a, rx_valid_a, done_a;
    logic [7:0]  rx_byte_a;
    logic [31:0] rx_word_a;
    logic        sclk_b, busy_b, rx_valid_b, done_b;
    logic [7:0]  rx_byte_b;
    logic [31:0] rx_word_b;

    logic        sclk_s, busy_s, rx_valid_s, done_s;
    logic [7:0]  rx_byte_s;
    logic [31:0] rx_word_s;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          bit_idx = 0;
    bit          dpend = 1'b0;
    bit          done_ok = 1'b0;
    logic [31:0] txw = 32'd0;

    typedef struct {
        logic [7:0] b;
        int         c;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_rx_ctrl #(.HALF_PERIOD(1), .MAX_BYTES(4)) u_a (
        .clk(clk), .rst(rst), .start(start & (both | ~sel)), .rx_len(rx_len),
        .dummy_en(dummy_en), .miso(miso), .sclk(sclk_a), .busy(busy_a),
        .rx_byte(rx_byte_a), .rx_valid(rx_valid_a), .rx_word(rx_word_a), .done(done_a)
    );

    spi_rx_ctrl #(.HALF_PERIOD(2), .MAX_BYTES(4)) u_b (
        .clk(clk), .rst(rst), .start(start & (both | sel)), .rx_len(rx_len),
        .dummy_en(dummy_en), .miso(miso), .sclk(sclk_b), .busy(busy_b),
        .rx_byte(rx_byte_b), .rx_valid(rx_valid_b), .rx_word(rx_word_b), .done(done_b)
    );

    assign sclk_s     = sel ? sclk_b     : sclk_a;
    assign busy_s     = sel ? busy_b     : busy_a;
    assign rx_valid_s = sel ? rx_valid_b : rx_valid_a;
    assign done_s     = sel ? done_b     : done_a;
    assign rx_byte_s  = sel ? rx_byte_b  : rx_byte_a;
    assign rx_word_s  = sel ? rx_word_b  : rx_word_a;

    // Panel model: drives the current bit, advances after each SCLK fall;
    // the dummy period's fall does not advance.
    assign miso = (bit_idx < 32) ? txw[5'(31 - bit_idx)] : 1'b0;
    always @(negedge sclk_s) begin
        #2;
        if (dpend) dpend = 1'b0;
        else       bit_idx++;
    end
    always @(posedge sclk_s) pulse_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rx_valid_s) begin
            if (exp_q.size() == 0) begin
                check("unexp_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rx_byte", 64'(rx_byte_s), 64'(e.b));
                check("valid_cyc", 64'(cyc), 64'(e.c));
            end
        end
        if (!rst && done_s && !done_ok) check("unexp_done", 64'd1, 64'd0);
    end

    task automatic do_read(input bit s, input logic [2:0] len, input logic d,
                           input logic [31:0] data, input bit poke);
        int          p, n, c0;
        bit          got;
        logic [31:0] wexp;
        logic [7:0]  b;
        p = s ? 4 : 2;
        n = (len == 3'd0) ? 1 : ((len > 3'd4) ? 4 : int'(len));
        @(negedge clk);
        sel = s;
        txw = data;
        bit_idx = 0;
        dpend = d;
        pulse_cnt = 0;
        c0 = cyc;
        wexp = 32'd0;
        for (int i = 0; i < n; i++) begin
            b = data[31 - 8*i -: 8];
            wexp = (wexp << 8) | {24'd0, b};
            exp_q.push_back('{b, c0 + 1 + p * (int'(d) + 8 * (i + 1))});
        end
        done_ok = 1'b1;
        start = 1'b1;
        rx_len = len;
        dummy_en = d;
        @(negedge clk);
        start = 1'b0;
        check("word_clr", 64'(rx_word_s), 64'd0);
        check("busy_start", 64'(busy_s), 64'd1);
        check("sclk_first", 64'(sclk_s), 64'd0);
        if (poke) begin
            rx_len = ~len;
            dummy_en = ~d;
            repeat (8) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int t = 0; t < 2000 && !got; t++) begin
            @(negedge clk);
            if (done_s) got = 1'b1;
        end
        check("done_seen", 64'(got), 64'd1);
        if (got) begin
            check("done_cyc", 64'(cyc), 64'(c0 + 1 + p * (int'(d) + 8 * n)));
            check("rx_word", 64'(rx_word_s), 64'(wexp));
            check("busy_done", 64'(busy_s), 64'd0);
            check("sclk_done", 64'(sclk_s), 64'd0);
            check("valid_done", 64'(rx_valid_s), 64'd1);
            check("pulses", 64'(pulse_cnt), 64'(8 * n + int'(d)));
            if (poke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("done_len", 64'(done_s), 64'd0);
            check("idle_busy", 64'(busy_s), 64'd0);
            check("word_hold", 64'(rx_word_s), 64'(wexp));
            @(negedge clk);
            check("no_restart", 64'(busy_s), 64'd0);
        end
        check("q_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        done_ok = 1'b0;
    endtask

    task automatic reset_mid;
        bit hit;
        int pc;
        @(negedge clk);
        sel = 1'b0;
        txw = 32'hF0F0_0000;
        bit_idx = 0;
        dpend = 1'b0;
        pulse_cnt = 0;
        start = 1'b1;
        rx_len = 3'd2;
        dummy_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(negedge clk);
            if (pulse_cnt >= 5) hit = 1'b1;
        end
        check("rst_5bits", 64'(hit), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy_s), 64'd0);
        check("rst_sclk", 64'(sclk_s), 64'd0);
        check("rst_word", 64'(rx_word_s), 64'd0);
        check("rst_valid", 64'(rx_valid_s), 64'd0);
        pc = pulse_cnt;
        repeat (40) @(negedge clk);
        check("rst_stay_idle", 64'(busy_s), 64'd0);
        check("rst_no_pulses", 64'(pulse_cnt), 64'(pc));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        both = 1'b1;
        rx_len = 3'd1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_sclk0", 64'({sclk_a, sclk_b}), 64'd0);
            check("rst_busy0", 64'({busy_a, busy_b}), 64'd0);
            check("rst_flags0", 64'({rx_valid_a, rx_valid_b, done_a, done_b}), 64'd0);
            check("rst_data0", {rx_byte_a, rx_byte_b, rx_word_a[15:0], rx_word_b[15:0]}, 64'd0);
            if (i == 2) begin
                rst = 1'b0;
                start = 1'b0;
            end
        end
        @(negedge clk);
        both = 1'b0;
        check("post_rst_idle", 64'({busy_a, busy_b, sclk_a, sclk_b}), 64'd0);

        do_read(1'b0, 3'd1, 1'b0, 32'hA500_0000, 1'b0);
        do_read(1'b1, 3'd3, 1'b1, 32'h0093_4100, 1'b0);
        do_read(1'b0, 3'd0, 1'b0, 32'h3C77_0000, 1'b0);
        do_read(1'b0, 3'd7, 1'b0, 32'hDEAD_BEEF, 1'b0);
        do_read(1'b1, 3'd7, 1'b0, 32'h0102_8040, 1'b0);
        do_read(1'b0, 3'd2, 1'b1, 32'h5AC3_0000, 1'b1);
        do_read(1'b1, 3'd1, 1'b0, 32'h6900_0000, 1'b1);
        reset_mid();
        do_read(1'b0, 3'd2, 1'b0, 32'h1234_0000, 1'b0);
        for (int r = 0; r < 3; r++)
            do_read(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), $urandom, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
